// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and downstream pipeline registers.
//   fetch_state_e : fetch controller states
//   HALT_WORD     : instruction encoding that stops fetch
//   NOP_WORD      : encoding used for flushed pipeline slots
//   ifid_t        : IF/ID payload {instruction, pcPlus4, valid}
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HALTED
    } fetch_state_e;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pcPlus4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/ifid_register.sv
// Generic IF/ID-style pipeline register.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (clears to a nop bubble)
//   load_i  : capture d_i
//   flush_i : replace instruction with NOP_WORD and clear valid (wins over load_i)
//   d_i     : payload to capture
//   q_o     : registered payload
// With neither load_i nor flush_i asserted the register holds.
module ifid_register
    import fetch_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  load_i,
    input  logic  flush_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t q_q;
    ifid_t q_d;

    always_comb begin
        q_d = q_q;
        if (flush_i) begin
            q_d.instruction = NOP_WORD;
            q_d.valid       = 1'b0;
        end else if (load_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '{instruction: NOP_WORD, pcPlus4: '0, valid: 1'b0};
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives InstructionMemory, fills the IF/ID register.
//   clock, resetN       : rising-edge clock, asynchronous active-low reset
//   instructionAddress  : PC presented to InstructionMemory
//   instructionIn       : combinational memory word for instructionAddress
//   stall               : hold PC and IF/ID
//   redirect            : branch/jump from execute; redirectTarget is new PC
//   ifIdInstruction     : registered instruction for decode
//   ifIdPcPlus4         : registered PC+4 of that instruction
//   ifIdValid           : IF/ID holds a real instruction
//   halted              : fetch stopped
//   fetchError          : stop caused by an illegal address
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 512,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        resetN,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instructionIn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic [31:0] ifIdInstruction,
    output logic [31:0] ifIdPcPlus4,
    output logic        ifIdValid,
    output logic        halted,
    output logic        fetchError
);

    import fetch_pkg::*;

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         halted_q, halted_d;
    logic         err_q, err_d;

    ifid_t ifid_q, ifid_d;
    logic  ifid_load, ifid_flush;

    logic        target_legal;
    logic [31:0] pc_plus4;

    assign target_legal = (redirectTarget[1:0] == 2'b00) && (redirectTarget <= LAST_PC);
    assign pc_plus4     = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        halted_d   = halted_q;
        err_d      = err_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        // Loading this payload only drops valid; instruction and pcPlus4 keep
        // their last values, which is what halting needs.
        ifid_d     = '{instruction: ifid_q.instruction, pcPlus4: ifid_q.pcPlus4, valid: 1'b0};

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect && !target_legal) begin
                    state_d   = HALTED;
                    halted_d  = 1'b1;
                    err_d     = 1'b1;
                    ifid_load = 1'b1;
                end else if (redirect) begin
                    pc_d       = redirectTarget;
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    // hold everything
                end else if (instructionIn == HALT_WORD) begin
                    state_d   = HALTED;
                    halted_d  = 1'b1;
                    ifid_load = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    ifid_d    = '{instruction: instructionIn, pcPlus4: pc_plus4, valid: 1'b1};
                    if (pc_q == LAST_PC) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            HALTED: begin
                ifid_load = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    ifid_register u_ifid (
        .clk_i   (clock),
        .rst_ni  (resetN),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign instructionAddress = pc_q;
    assign ifIdInstruction    = ifid_q.instruction;
    assign ifIdPcPlus4        = ifid_q.pcPlus4;
    assign ifIdValid          = ifid_q.valid;
    assign halted             = halted_q;
    assign fetchError         = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int unsigned IMEM = 512;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [31:0] instructionAddress;
    logic [31:0] instructionIn;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectTarget = '0;
    logic [31:0] ifIdInstruction;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic        halted;
    logic        fetchError;

    logic [31:0] mem [128];

    int checks = 0;
    int failures = 0;

    // reference model of the fetch stage
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted, m_err, m_boot;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (IMEM),
        .HALT_WORD  (HALTW)
    ) dut (
        .clock              (clock),
        .resetN             (resetN),
        .instructionAddress (instructionAddress),
        .instructionIn      (instructionIn),
        .stall              (stall),
        .redirect           (redirect),
        .redirectTarget     (redirectTarget),
        .ifIdInstruction    (ifIdInstruction),
        .ifIdPcPlus4        (ifIdPcPlus4),
        .ifIdValid          (ifIdValid),
        .halted             (halted),
        .fetchError         (fetchError)
    );

    always #5 clock = ~clock;

    assign instructionIn = (instructionAddress < IMEM) ? mem[instructionAddress[8:2]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},   instructionAddress, m_pc);
        check({tag, ".instr"},  ifIdInstruction,    m_instr);
        check({tag, ".pc4"},    ifIdPcPlus4,        m_pc4);
        check({tag, ".valid"},  {31'b0, ifIdValid},  {31'b0, m_valid});
        check({tag, ".halted"}, {31'b0, halted},     {31'b0, m_halted});
        check({tag, ".err"},    {31'b0, fetchError}, {31'b0, m_err});
    endtask

    function automatic void model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_boot = 1'b1;
    endfunction

    // One rising edge of the fetch stage, from the rules in plain terms.
    function automatic void model_step();
        logic [31:0] w;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (redirect) begin
            if ((redirectTarget % 4 != 0) || (redirectTarget > IMEM - 4)) begin
                m_halted = 1'b1; m_err = 1'b1; m_valid = 1'b0;
            end else begin
                m_pc = redirectTarget; m_instr = 32'h0; m_valid = 1'b0;
            end
        end else if (!stall) begin
            w = mem[m_pc / 4];
            if (w == HALTW) begin
                m_valid = 1'b0; m_halted = 1'b1;
            end else begin
                m_instr = w; m_pc4 = m_pc + 4; m_valid = 1'b1;
                if (m_pc + 4 == IMEM) begin
                    m_halted = 1'b1; m_err = 1'b1;
                end else begin
                    m_pc = m_pc + 4;
                end
            end
        end
    endfunction

    task automatic cycle(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        resetN = 1'b0; stall = 1'b0; redirect = 1'b0; redirectTarget = '0;
        #3;
        model_reset();
        check_all(tag);
        @(negedge clock);
        resetN = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALTW) w = 32'h0;
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = rand_word();
        mem[0] = 32'h2108_0008;
        mem[1] = 32'hAC08_0000;

        // reset release and first instructions
        do_reset("rst0");
        cycle("boot");
        check("boot_valid", {31'b0, ifIdValid}, 32'd0);
        cycle("e2");
        check("e2_instr", ifIdInstruction, 32'h2108_0008);
        check("e2_pc4", ifIdPcPlus4, 32'd4);
        cycle("e3");
        check("e3_instr", ifIdInstruction, 32'hAC08_0000);
        check("e3_pc4", ifIdPcPlus4, 32'd8);

        // stall three edges at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            check("stall_addr", instructionAddress, 32'd8);
        end
        stall = 1'b0;
        cycle("unstall");
        check("unstall_addr", instructionAddress, 32'd12);

        // redirect beats stall
        stall = 1'b1; redirect = 1'b1; redirectTarget = 32'h20;
        cycle("redir");
        check("redir_addr", instructionAddress, 32'h20);
        check("redir_valid", {31'b0, ifIdValid}, 32'd0);
        stall = 1'b0; redirect = 1'b0;
        cycle("redir_next");
        check("redir_next_pc4", ifIdPcPlus4, 32'h24);
        check("redir_next_instr", ifIdInstruction, mem[8]);

        // randomized stall / legal redirect traffic
        for (int i = 0; i < 200; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            redirectTarget = {$urandom_range(0, 127), 2'b00};
            cycle("rand");
        end
        stall = 1'b0; redirect = 1'b0;

        // halt word at 0x10
        mem[4] = HALTW;
        do_reset("rst1");
        for (int i = 0; i < 40 && !m_halted; i++) cycle("to_halt");
        check("hw_halted", {31'b0, halted}, 32'd1);
        check("hw_err", {31'b0, fetchError}, 32'd0);
        check("hw_valid", {31'b0, ifIdValid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            redirect = $urandom_range(0, 1);
            stall = $urandom_range(0, 1);
            redirectTarget = {$urandom_range(0, 127), 2'b00};
            cycle("hw_hold");
            check("hw_hold_addr", instructionAddress, 32'h10);
        end
        mem[4] = rand_word();

        // misaligned and out-of-range redirect targets
        for (int k = 0; k < 2; k++) begin
            do_reset("rst_bad");
            cycle("bad_boot");
            redirect = 1'b1;
            redirectTarget = (k == 0) ? 32'h22 : 32'h200;
            cycle("bad_redir");
            check("bad_halted", {31'b0, halted}, 32'd1);
            check("bad_err", {31'b0, fetchError}, 32'd1);
            check("bad_valid", {31'b0, ifIdValid}, 32'd0);
            redirect = 1'b0;
            cycle("bad_hold");
        end

        // run off the end of memory
        do_reset("rst2");
        cycle("end_boot");
        redirect = 1'b1; redirectTarget = 32'h1F0;
        cycle("end_redir");
        redirect = 1'b0;
        for (int i = 0; i < 20 && !m_halted; i++) cycle("to_end");
        check("end_halted", {31'b0, halted}, 32'd1);
        check("end_err", {31'b0, fetchError}, 32'd1);
        check("end_pc4", ifIdPcPlus4, 32'h200);
        check("end_instr", ifIdInstruction, mem[127]);
        check("end_valid", {31'b0, ifIdValid}, 32'd1);
        check("end_addr", instructionAddress, 32'h1FC);
        cycle("end_after");

        // asynchronous reset mid-FETCH at pc=0x40
        do_reset("rst3");
        cycle("mid_boot");
        redirect = 1'b1; redirectTarget = 32'h3C;
        cycle("mid_redir");
        redirect = 1'b0;
        cycle("mid_adv");
        check("mid_addr", instructionAddress, 32'h40);
        #3;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all("async");
        check("async_addr", instructionAddress, 32'h0);
        @(negedge clock);
        resetN = 1'b1;
        cycle("post_boot");
        check("post_boot_valid", {31'b0, ifIdValid}, 32'd0);
        cycle("post_first");
        check("post_first_pc4", ifIdPcPlus4, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of InstructionMemory.
- Owns the program counter and drives instructionAddress into the memory.
- Captures the returned 32-bit word into the IF/ID pipeline register for the decode stage.
- Handles stall from the hazard unit, branch/jump redirect from execute, a halt word, and out-of-range fetch detection.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset
IMEM_BYTES, 512, instruction memory size in bytes; legal PCs are 0 to IMEM_BYTES-4
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
clock  input  1  single clock; all state updates on the rising edge
resetN  input  1  asynchronous, active-low reset
instructionAddress  output  32  byte address to InstructionMemory; always equals the PC register
instructionIn  input  32  combinational word returned by InstructionMemory for instructionAddress
stall  input  1  hazard unit: hold PC and IF/ID
redirect  input  1  execute stage: branch taken or jump
redirectTarget  input  32  new PC when redirect=1
ifIdInstruction  output  32  registered instruction to decode
ifIdPcPlus4  output  32  registered PC+4 of that instruction
ifIdValid  output  1  IF/ID holds a real instruction (0 = bubble)
halted  output  1  fetch stopped
fetchError  output  1  stop was caused by an illegal address

Behaviour:
- Reset (resetN=0, asynchronous), value of every register:
  - pc=RESET_PC; state=BOOT.
  - ifIdInstruction=0 (nop); ifIdPcPlus4=0; ifIdValid=0.
  - halted=0; fetchError=0.
- Reset asserted mid-operation: all of the above applies immediately, regardless of state.
- States: BOOT, FETCH, HALTED.
- BOOT: one cycle after resetN rises.
  - pc holds; IF/ID stays a bubble.
  - Next state is FETCH. Covers memory settle time.
- FETCH, per cycle, first matching rule wins:
  1. redirect=1 and redirectTarget illegal (target[1:0]!=0 or target>IMEM_BYTES-4):
     - state<=HALTED; halted<=1; fetchError<=1.
     - ifIdValid<=0; pc holds.
  2. redirect=1 and target legal:
     - pc<=redirectTarget.
     - ifIdInstruction<=0; ifIdValid<=0 (one-bubble flush).
     - Redirect overrides stall and the halt word.
  3. stall=1: pc, ifIdInstruction, ifIdPcPlus4 and ifIdValid all hold.
  4. instructionIn==HALT_WORD:
     - The halt word is not forwarded: ifIdValid<=0.
     - state<=HALTED; halted<=1; pc holds.
  5. Otherwise (normal advance):
     - ifIdInstruction<=instructionIn; ifIdPcPlus4<=pc+4; ifIdValid<=1.
     - If pc==IMEM_BYTES-4: pc holds; state<=HALTED; halted<=1; fetchError<=1. The last instruction is still delivered.
     - Else pc<=pc+4.
- HALTED:
  - pc and halted/fetchError hold.
  - ifIdValid<=0 on the first HALTED edge, then stays 0.
  - stall and redirect are ignored; only resetN leaves this state.
- Latency:
  - Memory read is combinational.
  - An instruction at pc appears on ifIdInstruction one edge after pc is presented.
  - First valid instruction arrives on the 2nd rising edge after reset release (BOOT + FETCH).
- Arithmetic:
  - pc+4 is a 32-bit unsigned add.
  - Overflow cannot occur because PC is bounded by IMEM_BYTES.
- instructionAddress is pc directly; no combinational path from redirect to instructionAddress.

Decomposition:
- Shared package (fetch_pkg) holds:
  - the state enum {BOOT, FETCH, HALTED};
  - the HALT_WORD and NOP_WORD (32'h0) constants;
  - a struct type ifid_t {instruction, pcPlus4, valid}, reused by the decode stage.
- One natural sub-module: ifid_register.
  - Holds the IF/ID payload.
  - Has load, hold and flush controls.
  - Reused for later pipeline registers.
- PC/next-PC logic and the FSM stay in the top module.

Test Plan:
- Reset release, memory holds addi at 0 and sw at 4:
  - Edge 1 after release: ifIdValid=0.
  - Edge 2: ifIdInstruction=32'h2108_0008, ifIdPcPlus4=4.
  - Edge 3: ifIdInstruction=32'hAC08_0000, ifIdPcPlus4=8.
- stall=1 for 3 cycles at pc=8: instructionAddress stays 8 and IF/ID is unchanged for 3 edges, then advances to pc=12.
- redirect=1 with target=0x20 while stall=1 at pc=12:
  - Next edge: pc=0x20, ifIdValid=0.
  - Following edge: word at 0x20 is valid with ifIdPcPlus4=0x24.
- HALT_WORD at 0x10: after the edge, halted=1, fetchError=0, ifIdValid=0; pc stays 0x10 for 10 further cycles despite redirect pulses.
- redirect target=0x22 (misaligned), and in a separate run target=0x200: halted=1, fetchError=1, ifIdValid=0.
- Sequential run to pc=0x1FC:
  - Word at 0x1FC is delivered with ifIdPcPlus4=0x200.
  - halted=1 and fetchError=1 on the same edge; pc stays 0x1FC.
- resetN pulsed low mid-FETCH at pc=0x40: outputs clear asynchronously, without waiting for a clock edge; pc=0 and state=BOOT.
